// File: rtl/uart_cmd_if.sv
// Byte stream from the UART receiver plus the audio configuration/status
// outputs of the command controller.
interface uart_cmd_if;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       RX_FERR;
    logic [7:0] VOLUME;
    logic [7:0] NOTE;
    logic [1:0] WAVE;
    logic       ENABLE;
    logic       BUSY;
    logic       CMD_OK;
    logic       CMD_ERR;
    logic [2:0] ERR_CODE;
    logic [7:0] CMD_COUNT;

    modport master (
        output RX_DATA, RX_VALID, RX_FERR,
        input  VOLUME, NOTE, WAVE, ENABLE, BUSY, CMD_OK, CMD_ERR, ERR_CODE, CMD_COUNT
    );

    modport slave (
        input  RX_DATA, RX_VALID, RX_FERR,
        output VOLUME, NOTE, WAVE, ENABLE, BUSY, CMD_OK, CMD_ERR, ERR_CODE, CMD_COUNT
    );
endinterface

// File: rtl/uart_cmd_controller.sv
// Parses SYNC/ADDR/DATA/CHK packets from the UART receiver, validates them and
// writes the audio configuration registers; reports completion and errors.
module uart_cmd_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 500000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input logic       CLK50MHz,
    input logic       RESET,
    uart_cmd_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_CHECK, S_APPLY} state_t;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_CHK     = 3'd1;
    localparam logic [2:0] ERR_ADDR    = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT = 3'd3;
    localparam logic [2:0] ERR_FRAME   = 3'd4;
    // Compared against the pre-increment count: the abort lands on the edge
    // where the counter would reach TIMEOUT_CYCLES-1.
    localparam logic [19:0] TIMER_LAST = 20'(TIMEOUT_CYCLES - 2);

    state_t      state_q, state_d;
    logic [19:0] timer_q, timer_d;
    logic [7:0]  addr_q, data_q;
    logic        latch_addr, latch_data;
    logic        byte_ok, sync_seen;

    logic [7:0]  volume_q, volume_d;
    logic [7:0]  note_q, note_d;
    logic [1:0]  wave_q, wave_d;
    logic        enable_q, enable_d;
    logic        busy_q;
    logic        cmd_ok_q, cmd_ok_d;
    logic        cmd_err_q, cmd_err_d;
    logic [2:0]  err_code_q, err_code_d;
    logic [7:0]  cmd_count_q, cmd_count_d;

    function automatic logic [7:0] checksum(input logic [7:0] a, input logic [7:0] d);
        logic [7:0] sum;
        sum = a + d;
        return ~sum;
    endfunction

    assign byte_ok   = bus.RX_VALID && !bus.RX_FERR;
    assign sync_seen = byte_ok && (bus.RX_DATA == SYNC_BYTE);

    always_ff @(posedge CLK50MHz or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        latch_addr  = 1'b0;
        latch_data  = 1'b0;
        volume_d    = volume_q;
        note_d      = note_q;
        wave_d      = wave_q;
        enable_d    = enable_q;
        cmd_ok_d    = 1'b0;
        cmd_err_d   = 1'b0;
        err_code_d  = err_code_q;
        cmd_count_d = cmd_count_q;
        case (state_q)
            S_IDLE: begin
                if (sync_seen) begin
                    state_d = S_ADDR;
                    timer_d = '0;
                end
            end
            S_APPLY: begin
                case (addr_q)
                    8'h00:   volume_d = data_q;
                    8'h01:   note_d   = data_q;
                    default: begin
                        wave_d   = data_q[2:1];
                        enable_d = data_q[0];
                    end
                endcase
                cmd_ok_d    = 1'b1;
                err_code_d  = ERR_NONE;
                cmd_count_d = cmd_count_q + 8'd1;
                state_d     = S_IDLE;
                // A SYNC landing in the apply cycle starts the next packet at once.
                if (sync_seen) begin
                    state_d = S_ADDR;
                    timer_d = '0;
                end
            end
            default: begin
                timer_d = timer_q + 20'd1;
                if (bus.RX_VALID && bus.RX_FERR) begin
                    state_d    = S_IDLE;
                    cmd_err_d  = 1'b1;
                    err_code_d = ERR_FRAME;
                end else if (bus.RX_VALID) begin
                    timer_d = '0;
                    case (state_q)
                        S_ADDR: begin
                            latch_addr = 1'b1;
                            state_d    = S_DATA;
                        end
                        S_DATA: begin
                            latch_data = 1'b1;
                            state_d    = S_CHECK;
                        end
                        default: begin
                            if (bus.RX_DATA != checksum(addr_q, data_q)) begin
                                state_d    = S_IDLE;
                                cmd_err_d  = 1'b1;
                                err_code_d = ERR_CHK;
                            end else if (addr_q > 8'h02) begin
                                state_d    = S_IDLE;
                                cmd_err_d  = 1'b1;
                                err_code_d = ERR_ADDR;
                            end else begin
                                state_d = S_APPLY;
                            end
                        end
                    endcase
                end else if (timer_q == TIMER_LAST) begin
                    state_d    = S_IDLE;
                    cmd_err_d  = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                end
            end
        endcase
    end

    always_ff @(posedge CLK50MHz) begin
        if (latch_addr) addr_q <= bus.RX_DATA;
        if (latch_data) data_q <= bus.RX_DATA;
    end

    always_ff @(posedge CLK50MHz or negedge RESET) begin
        if (!RESET) begin
            volume_q    <= 8'h80;
            note_q      <= 8'h00;
            wave_q      <= 2'd0;
            enable_q    <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ok_q    <= 1'b0;
            cmd_err_q   <= 1'b0;
            err_code_q  <= ERR_NONE;
            cmd_count_q <= 8'h00;
        end else begin
            volume_q    <= volume_d;
            note_q      <= note_d;
            wave_q      <= wave_d;
            enable_q    <= enable_d;
            busy_q      <= (state_d != S_IDLE);
            cmd_ok_q    <= cmd_ok_d;
            cmd_err_q   <= cmd_err_d;
            err_code_q  <= err_code_d;
            cmd_count_q <= cmd_count_d;
        end
    end

    assign bus.VOLUME    = volume_q;
    assign bus.NOTE      = note_q;
    assign bus.WAVE      = wave_q;
    assign bus.ENABLE    = enable_q;
    assign bus.BUSY      = busy_q;
    assign bus.CMD_OK    = cmd_ok_q;
    assign bus.CMD_ERR   = cmd_err_q;
    assign bus.ERR_CODE  = err_code_q;
    assign bus.CMD_COUNT = cmd_count_q;
endmodule

// File: tb/tb_uart_cmd_controller.sv
// Scoreboard bench for uart_cmd_controller: a packet-level model predicts every
// CMD_OK/CMD_ERR event (cycle and register snapshot); a monitor compares them.
module tb_uart_cmd_controller;
    localparam int unsigned T    = 100;
    localparam logic [7:0]  SYNC = 8'hA5;

    typedef struct {
        int unsigned at;
        logic        ok;
        logic [2:0]  code;
        logic [7:0]  vol;
        logic [7:0]  note;
        logic [1:0]  wave;
        logic        en;
        logic [7:0]  cnt;
    } ev_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int unsigned cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    ev_t        exp_q[$];
    logic [7:0] m_pkt[$];
    int unsigned m_last;
    logic [7:0] m_vol, m_note, m_cnt;
    logic [1:0] m_wave;
    logic       m_en;
    logic [2:0] m_code;

    uart_cmd_if bus();

    uart_cmd_controller #(.TIMEOUT_CYCLES(T), .SYNC_BYTE(SYNC)) dut (
        .CLK50MHz(clk),
        .RESET   (rst_n),
        .bus     (bus)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #(20 * 200000);
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic model_reset();
        m_pkt.delete();
        m_vol = 8'h80; m_note = 8'h00; m_wave = 2'd0; m_en = 1'b0;
        m_cnt = 8'h00; m_code = 3'd0; m_last = 0;
    endtask

    task automatic push_ev(input int unsigned at, input logic ok);
        ev_t e;
        e.at = at; e.ok = ok; e.code = m_code; e.vol = m_vol; e.note = m_note;
        e.wave = m_wave; e.en = m_en; e.cnt = m_cnt;
        exp_q.push_back(e);
    endtask

    // A packet in progress dies T-1 edges after its last accepted byte unless a
    // byte is sampled on or before that edge.
    task automatic model_flush(input int unsigned s);
        if (m_pkt.size() != 0 && s > m_last + T - 1) begin
            m_code = 3'd3;
            push_ev(m_last + T - 1, 1'b0);
            m_pkt.delete();
        end
    endtask

    task automatic model_byte(input int unsigned s, input logic [7:0] d, input logic ferr);
        logic [7:0] sum;
        model_flush(s);
        if (m_pkt.size() == 0) begin
            if (!ferr && d == SYNC) begin
                m_pkt.push_back(d);
                m_last = s;
            end
        end else if (ferr) begin
            m_code = 3'd4;
            push_ev(s, 1'b0);
            m_pkt.delete();
        end else begin
            m_pkt.push_back(d);
            m_last = s;
            if (m_pkt.size() == 4) begin
                sum = m_pkt[1] + m_pkt[2];
                if (d != ~sum) begin
                    m_code = 3'd1;
                    push_ev(s, 1'b0);
                end else if (m_pkt[1] > 8'd2) begin
                    m_code = 3'd2;
                    push_ev(s, 1'b0);
                end else begin
                    if (m_pkt[1] == 8'd0) m_vol = m_pkt[2];
                    else if (m_pkt[1] == 8'd1) m_note = m_pkt[2];
                    else begin
                        m_wave = m_pkt[2][2:1];
                        m_en   = m_pkt[2][0];
                    end
                    m_code = 3'd0;
                    m_cnt  = m_cnt + 8'd1;
                    push_ev(s + 1, 1'b1);
                end
                m_pkt.delete();
            end
        end
    endtask

    // Called on a falling edge; the byte is sampled gap+1 rising edges later.
    task automatic drive_byte(input logic [7:0] d, input logic ferr, input int unsigned gap);
        model_byte(cyc + 1 + gap, d, ferr);
        repeat (gap) @(negedge clk);
        bus.RX_DATA = d; bus.RX_FERR = ferr; bus.RX_VALID = 1'b1;
        @(negedge clk);
        bus.RX_VALID = 1'b0; bus.RX_FERR = 1'b0; bus.RX_DATA = 8'($urandom);
    endtask

    task automatic idle(input int unsigned n);
        model_flush(cyc + n + 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_pkt(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
        drive_byte(SYNC, 1'b0, 0);
        drive_byte(a, 1'b0, 0);
        drive_byte(d, 1'b0, 0);
        drive_byte(c, 1'b0, 0);
    endtask

    function automatic logic [7:0] chk_of(input logic [7:0] a, input logic [7:0] d);
        logic [7:0] sum;
        sum = a + d;
        return ~sum;
    endfunction

    function automatic int unsigned rnd_gap();
        if ($urandom_range(0, 9) == 0) return $urandom_range(T - 5, T + 2);
        return $urandom_range(0, 3);
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_volume"}, bus.VOLUME, 8'h80);
        check({tag, "_note"}, bus.NOTE, 8'h00);
        check({tag, "_wave"}, bus.WAVE, 2'd0);
        check({tag, "_enable"}, bus.ENABLE, 1'b0);
        check({tag, "_busy"}, bus.BUSY, 1'b0);
        check({tag, "_cmd_ok"}, bus.CMD_OK, 1'b0);
        check({tag, "_cmd_err"}, bus.CMD_ERR, 1'b0);
        check({tag, "_err_code"}, bus.ERR_CODE, 3'd0);
        check({tag, "_cmd_count"}, bus.CMD_COUNT, 8'h00);
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (rst_n && (bus.CMD_OK || bus.CMD_ERR)) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_event: got ok=%0b err=%0b code=%0d, expected no event (cycle %0d)",
                         bus.CMD_OK, bus.CMD_ERR, bus.ERR_CODE, cyc);
            end else begin
                e = exp_q.pop_front();
                check("event_cycle", cyc, e.at);
                check("event_fields",
                      {bus.CMD_OK, bus.CMD_ERR, bus.ERR_CODE, bus.VOLUME, bus.NOTE, bus.WAVE, bus.ENABLE, bus.CMD_COUNT},
                      {e.ok, !e.ok, e.code, e.vol, e.note, e.wave, e.en, e.cnt});
            end
        end
    end

    initial begin
        logic [7:0] a, d, c;
        logic [7:0] cnt_before;
        int unsigned t0, t1, kind;
        logic found;

        bus.RX_DATA = 8'h00; bus.RX_VALID = 1'b0; bus.RX_FERR = 1'b0;
        model_reset();

        // Reset held with random strobes on the receive side
        repeat (12) begin
            @(negedge clk);
            bus.RX_VALID = 1'($urandom_range(0, 1));
            bus.RX_FERR  = 1'($urandom_range(0, 1));
            bus.RX_DATA  = ($urandom_range(0, 1) == 1) ? SYNC : 8'($urandom);
        end
        check_reset_values("in_reset");
        @(negedge clk);
        bus.RX_VALID = 1'b0; bus.RX_FERR = 1'b0;
        rst_n = 1'b1;
        check("volume_after_release", bus.VOLUME, 8'h80);
        idle(2);

        // Directed packets
        send_pkt(8'h00, 8'h40, 8'hBF); idle(3);
        check("volume_write", bus.VOLUME, 8'h40);
        check("count_one", bus.CMD_COUNT, 8'd1);
        send_pkt(8'h02, 8'h05, 8'hF8); idle(3);
        check("enable_write", bus.ENABLE, 1'b1);
        check("wave_write", bus.WAVE, 2'd2);
        check("count_two", bus.CMD_COUNT, 8'd2);
        send_pkt(8'h01, 8'h3C, 8'hC3); idle(3);
        check("chk_err_code", bus.ERR_CODE, 3'd1);
        check("note_unchanged", bus.NOTE, 8'h00);
        send_pkt(8'h01, 8'h3C, 8'hC2); idle(3);
        check("note_write", bus.NOTE, 8'h3C);
        check("err_cleared", bus.ERR_CODE, 3'd0);
        send_pkt(8'h03, 8'h00, 8'hFC); idle(3);
        check("bad_addr_code", bus.ERR_CODE, 3'd2);
        drive_byte(SYNC, 1'b0, 0);
        drive_byte(8'h12, 1'b1, 0);
        check("ferr_code", bus.ERR_CODE, 3'd4);
        check("ferr_busy", bus.BUSY, 1'b0);
        idle(2);

        // Timeout: abort exactly T-1 cycles after BUSY rises
        drive_byte(SYNC, 1'b0, 0);
        t0 = cyc; t1 = 0; found = 1'b0;
        check("busy_rise", bus.BUSY, 1'b1);
        model_flush(cyc + 151);
        for (int i = 0; i < 150 && !found; i++) begin
            @(negedge clk);
            if (bus.CMD_ERR) begin
                found = 1'b1;
                t1 = cyc;
            end
        end
        check("timeout_seen", found, 1'b1);
        check("timeout_latency", t1 - t0, T - 1);
        check("timeout_code", bus.ERR_CODE, 3'd3);
        check("timeout_busy", bus.BUSY, 1'b0);
        idle(2);

        // Byte on the terminal count wins over the timeout
        drive_byte(SYNC, 1'b0, 0);
        drive_byte(8'h00, 1'b0, T - 2);
        drive_byte(8'h55, 1'b0, 0);
        drive_byte(8'hAA, 1'b0, 0);
        idle(3);
        check("late_byte_volume", bus.VOLUME, 8'h55);
        check("late_byte_code", bus.ERR_CODE, 3'd0);

        // Randomized packet stream
        for (int n = 0; n < 200; n++) begin
            kind = $urandom_range(0, 9);
            a = 8'($urandom_range(0, 2));
            d = 8'($urandom);
            if (kind == 7) a = 8'($urandom_range(3, 255));
            c = chk_of(a, d);
            if (kind == 6) c = c ^ (8'h01 << $urandom_range(0, 7));
            if (kind == 9) begin
                drive_byte(8'($urandom), 1'($urandom_range(0, 1)), rnd_gap());
            end else if (kind == 8) begin
                drive_byte(SYNC, 1'b0, rnd_gap());
                drive_byte(8'($urandom), 1'b1, rnd_gap());
            end else begin
                drive_byte(SYNC, 1'b0, rnd_gap());
                drive_byte(a, 1'b0, rnd_gap());
                drive_byte(d, 1'b0, rnd_gap());
                drive_byte(c, 1'b0, rnd_gap());
            end
        end
        idle(T + 5);

        // 256 back-to-back packets; each SYNC lands in the previous APPLY cycle
        cnt_before = m_cnt;
        for (int n = 0; n < 256; n++) begin
            a = 8'($urandom_range(0, 2));
            d = 8'($urandom);
            send_pkt(a, d, chk_of(a, d));
        end
        idle(5);
        check("count_wrap", bus.CMD_COUNT, cnt_before);

        // Reset mid-packet: partial packet discarded, no event afterwards
        drive_byte(SYNC, 1'b0, 0);
        drive_byte(8'h01, 1'b0, 0);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_values("mid_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(T + 20);
        check("post_reset_busy", bus.BUSY, 1'b0);

        idle(5);
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_cmd_controller.md
# uart_cmd_controller

Command sequencer behind the 9600-baud UART receiver. Consumes received bytes (one-cycle valid strobes in the CLK50MHz domain), parses 4-byte command packets, validates them, and drives the audio block's configuration registers. Reports completion, errors and a success count.

## Interface
- TIMEOUT_CYCLES, 500000: inter-byte timeout in CLK50MHz cycles (10 ms); legal range 2 to 2^20-1.
- SYNC_BYTE, 8'hA5: packet start marker.
- CLK50MHz  in  1  system clock.
- RESET  in  1  reset, asynchronous, active-low.
- RX_DATA  in  8  received byte; valid only while RX_VALID=1.
- RX_VALID  in  1  one-cycle strobe, one per received byte.
- RX_FERR  in  1  framing error flag, qualified by RX_VALID.
- VOLUME  out  8  audio volume register (addr 0x00).
- NOTE  out  8  note index register (addr 0x01).
- WAVE  out  2  waveform select (addr 0x02 bits 2:1).
- ENABLE  out  1  audio enable (addr 0x02 bit 0).
- BUSY  out  1  high while FSM is not in IDLE.
- CMD_OK  out  1  one-cycle pulse on successful register write.
- CMD_ERR  out  1  one-cycle pulse on any packet abort.
- ERR_CODE  out  3  last error: 0 none, 1 checksum, 2 bad address, 3 timeout, 4 framing.
- CMD_COUNT  out  8  count of successful commands, wraps 255->0.

## Operation
- Packet: SYNC_BYTE, ADDR, DATA, CHK. CHK = ~((ADDR + DATA) mod 256).
- States: IDLE, ADDR, DATA, CHECK, APPLY.
- IDLE: byte == SYNC_BYTE with RX_FERR=0 -> ADDR. All other bytes are ignored with no error.
- ADDR: latch byte, then -> DATA. A SYNC_BYTE value here is latched as an address and is rejected later as a bad address. No resync occurs.
- DATA: latch byte, then -> CHECK.
- CHECK: on byte, evaluate in this priority order:
  - Checksum mismatch -> ERR_CODE=1.
  - ADDR > 0x02 -> ERR_CODE=2.
  - Otherwise -> APPLY.
  - Both error cases pulse CMD_ERR and return to IDLE.
- APPLY (one cycle):
  - Write the latched DATA to the addressed register. For addr 0x02, bits 7:3 are discarded.
  - Pulse CMD_OK, set ERR_CODE=0, increment CMD_COUNT, then -> IDLE.
  - An RX_VALID arriving during APPLY is processed with IDLE rules.
- Framing: RX_VALID with RX_FERR=1 in IDLE is ignored. In ADDR, DATA or CHECK it aborts: ERR_CODE=4, CMD_ERR pulse, -> IDLE.
- Timeout counter (20 bits):
  - Cleared on entry to ADDR and on every accepted byte.
  - Increments each cycle in ADDR, DATA and CHECK.
  - Reaching TIMEOUT_CYCLES-1 without a byte: ERR_CODE=3, CMD_ERR pulse, -> IDLE.
  - If RX_VALID coincides with that terminal count, the byte wins and timeout is not flagged.
- ERR_CODE is sticky: it holds until the next error or the next CMD_OK.
- Config registers change only in APPLY.

## Timing
- Reset values (async, immediate): VOLUME=8'h80, NOTE=0, WAVE=0, ENABLE=0, BUSY=0, CMD_OK=0, CMD_ERR=0, ERR_CODE=0, CMD_COUNT=0. FSM resets to IDLE, timeout counter to 0.
- All outputs are registered.
- Edge k samples the CHK byte's RX_VALID -> FSM enters APPLY.
- Edge k+1: the register, CMD_OK=1, CMD_COUNT and ERR_CODE all update together. CMD_OK is high for exactly one cycle.
- Error aborts: CMD_ERR and ERR_CODE update on the same edge that samples the offending byte or the terminal timeout count. BUSY falls on that edge.
- BUSY rises on the edge that accepts SYNC_BYTE. It falls on the APPLY->IDLE edge, or on the abort edge for error cases.
- Reset asserted mid-packet: the partial packet is discarded; no CMD_OK or CMD_ERR is produced.
- Back-to-back packets at line rate need no idle gap.

## Test plan
- Reset: hold RESET=0 and apply random RX_VALID -> all outputs at reset values. After release, VOLUME=0x80.
- Good writes: send A5 00 40 BF -> VOLUME=0x40, CMD_OK one cycle at k+1, CMD_COUNT=1. Then send A5 02 05 F8 -> ENABLE=1, WAVE=2, CMD_COUNT=2.
- Checksum error: send A5 01 3C C3 -> CMD_ERR pulse, ERR_CODE=1, NOTE unchanged. Then send A5 01 3C C2 -> NOTE=0x3C, ERR_CODE=0.
- Bad address and framing: send A5 03 00 FC -> ERR_CODE=2. Send A5 then a byte with RX_FERR=1 -> ERR_CODE=4, BUSY=0.
- Timeout (TIMEOUT_CYCLES=100): send A5 then nothing -> CMD_ERR and ERR_CODE=3 exactly 99 cycles after BUSY rises. In a second run, deliver a byte on cycle 99 -> no timeout.
- Wrap: send 256 good packets -> CMD_COUNT returns to 0. A byte strobed during the APPLY cycle must be accepted as SYNC.
